microseq_control_unit: RTL and testbench

Parametrised microcoded sequencer that replaces the fixed-width control unit. It fetches a microword per cycle from a microcode ROM and drives its control field as the datapath enables. Sequencing comes from an explicit sequencing field: next, jump, opcode dispatch through a dispatch ROM, conditional jump on a flag bit, reset, and wait-for-ready. It also adds pipeline stall, an illegal-opcode trap, and a handshake-based wait.

---
 rtl/microseq_control_unit.sv | 161 ++++++++++++++++
 tb/tb_microseq_control_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_control_unit.sv
// Microcoded sequencer: fetches one microword per cycle from a constant ROM image,
// drives its control field onto the datapath, and picks the next micro-address
// from the word's sequencing field (next/jump/dispatch/conditional/reset/wait).
// ROM contents arrive as packed parameter images (word i at [i*W +: W]) so that
// the block carries no initialisation code and synthesises straight to ROM.
module microseq_control_unit #(
  parameter int CTRL_W            = 17,
  parameter int UADDR_W           = 6,
  parameter int UDEPTH            = 36,
  parameter int IR_W              = 16,
  parameter int OPCODE_W          = 5,
  parameter int FLAGS_W           = 4,
  parameter int DATA_W            = 8,
  parameter int FLAG_LD_ALU_BIT   = 0,
  parameter int FLAG_LD_STACK_BIT = 16,
  parameter int FLAG_OUT_BIT      = 14,
  parameter int IMM_OUT_BIT       = 11,
  parameter int ILLEGAL_UADDR     = 0,
  // Microword image: {seq[2:0], cond[2:0], target[UADDR_W-1:0], ctrl[CTRL_W-1:0]}
  parameter logic [UDEPTH*(6+UADDR_W+CTRL_W)-1:0]        UCODE_IMAGE    = '0,
  // Dispatch image: {valid, uaddr[UADDR_W-1:0]} per opcode
  parameter logic [(2**OPCODE_W)*(1+UADDR_W)-1:0]        DISPATCH_IMAGE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IR_W-1:0]     in_ir,
  input  logic [FLAGS_W-1:0]  in_alu_flags,
  input  logic [FLAGS_W-1:0]  in_stack_flags,
  input  logic                in_stall,
  input  logic                in_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [DATA_W-1:0]   out_cu_out,
  output logic                out_cu_out_en,
  output logic [FLAGS_W-1:0]  out_flags,
  output logic [UADDR_W-1:0]  out_micro_pc,
  output logic                out_illegal
);

  localparam int UWORD_W    = 6 + UADDR_W + CTRL_W;
  localparam int DISP_W     = 1 + UADDR_W;
  localparam int DISP_DEPTH = 2 ** OPCODE_W;
  localparam logic [UADDR_W:0] DEPTH_L = (UADDR_W + 1)'(UDEPTH);

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_DISPATCH = 3'd2,
    SEQ_CJT      = 3'd3,
    SEQ_CJF      = 3'd4,
    SEQ_RESET    = 3'd5,
    SEQ_WAIT     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_e;

  // NOTE: the ROMs are pure constants, so they have no reset; only micro_pc and flags are state.
  logic [UWORD_W-1:0] ucode    [UDEPTH];
  logic [DISP_W-1:0]  dispatch [DISP_DEPTH];

  for (genvar i = 0; i < UDEPTH; i++) begin : g_ucode
    assign ucode[i] = UCODE_IMAGE[i*UWORD_W +: UWORD_W];
  end
  for (genvar i = 0; i < DISP_DEPTH; i++) begin : g_disp
    assign dispatch[i] = DISPATCH_IMAGE[i*DISP_W +: DISP_W];
  end

  logic [UADDR_W-1:0]  micro_pc, micro_pc_next, pc_inc, target;
  logic [FLAGS_W-1:0]  flags, flags_next;
  logic [UWORD_W-1:0]  word;
  logic [CTRL_W-1:0]   ctrl;
  logic [2:0]          cond;
  logic [OPCODE_W-1:0] opcode;
  logic [DISP_W-1:0]   disp_entry;
  logic                in_range, cond_true, illegal;
  logic                unused_ir;
  seq_e                seq;

  // Addresses past the populated words fetch an all-zero word and restart at 0.
  assign in_range   = ({1'b0, micro_pc} < DEPTH_L);
  assign word       = in_range ? ucode[micro_pc] : '0;
  assign seq        = seq_e'(word[UWORD_W-1 -: 3]);
  assign cond       = word[UWORD_W-4 -: 3];
  assign target     = word[CTRL_W +: UADDR_W];
  assign ctrl       = word[CTRL_W-1:0];
  assign pc_inc     = micro_pc + UADDR_W'(1);
  assign opcode     = in_ir[IR_W-1 -: OPCODE_W];
  assign disp_entry = dispatch[opcode];
  assign unused_ir  = ^in_ir;

  // Condition select: codes beyond the flag width mean "always true".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cond_true = 1'b1;
    for (int i = 0; i < FLAGS_W; i++) begin
      if (int'(cond) == i) cond_true = flags[i];
    end
  end

  // Next micro-address and flag update; a stall freezes both.
  always_comb begin
    micro_pc_next = micro_pc;
    flags_next    = flags;
    illegal       = 1'b0;
    if (!in_stall) begin
      if (ctrl[FLAG_LD_ALU_BIT])   flags_next = in_alu_flags;
      if (ctrl[FLAG_LD_STACK_BIT]) flags_next = in_stack_flags;  // stack load wins
      if (!in_range) begin
        micro_pc_next = '0;
      end else begin
        case (seq)
          SEQ_NEXT: micro_pc_next = pc_inc;
          SEQ_JUMP: micro_pc_next = target;
          SEQ_DISPATCH: begin
            if (disp_entry[DISP_W-1]) begin
              micro_pc_next = disp_entry[UADDR_W-1:0];
            end else begin
              micro_pc_next = UADDR_W'(ILLEGAL_UADDR);
              illegal       = 1'b1;
            end
          end
          SEQ_CJT:  micro_pc_next = cond_true ? target : pc_inc;
          SEQ_CJF:  micro_pc_next = cond_true ? pc_inc : target;
          SEQ_WAIT: micro_pc_next = in_ready ? pc_inc : micro_pc;
          default:  micro_pc_next = '0;  // RESET and the reserved code
        endcase
      end
    end
  end

  // Sequencer state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      micro_pc <= '0;
      flags    <= '0;
    end else begin
      micro_pc <= micro_pc_next;
      flags    <= flags_next;
    end
  end

  // Output bus mux: flags have priority over the immediate; nothing drives while stalled.
  always_comb begin
    out_cu_out    = '0;
    out_cu_out_en = 1'b0;
    if (!in_stall) begin
      if (ctrl[FLAG_OUT_BIT]) begin
        out_cu_out[FLAGS_W-1:0] = flags;
        out_cu_out_en           = 1'b1;
      end else if (ctrl[IMM_OUT_BIT]) begin
        out_cu_out    = in_ir[DATA_W-1:0];
        out_cu_out_en = 1'b1;
      end
    end
  end

  assign out_ctrl     = in_stall ? '0 : ctrl;
  assign out_illegal  = illegal & ~reset;
  assign out_flags    = flags;
  assign out_micro_pc = micro_pc;

endmodule

// File: tb/tb_microseq_control_unit.sv
// Directed bench for microseq_control_unit: a 36-word program exercising reset,
// dispatch, conditional branches, flag priority, stall, WAIT and out-of-range
// fetch, plus a 64-word instance for micro-address wrap-around.
module tb_microseq_control_unit;

  localparam int UW = 29;  // 3 + 3 + 6 + 17
  localparam int DW = 7;   // 1 + 6

  localparam logic [2:0] S_NEXT = 3'd0, S_JUMP = 3'd1, S_DISP = 3'd2, S_CJT = 3'd3,
                         S_CJF = 3'd4, S_RST = 3'd5, S_WAIT = 3'd6;

  function automatic logic [UW-1:0] uw(input logic [2:0] s, input logic [2:0] c,
                                       input logic [5:0] t, input logic [16:0] k);
    return {s, c, t, k};
  endfunction

  function automatic logic [36*UW-1:0] build_ucode_a();
    logic [36*UW-1:0] img;
    img = '0;
    img[ 0*UW +: UW] = uw(S_DISP, 3'd0, 6'd0,  17'h00002);
    img[ 2*UW +: UW] = uw(S_NEXT, 3'd0, 6'd0,  17'h00005);
    img[ 3*UW +: UW] = uw(S_CJT,  3'd0, 6'd6,  17'h00008);
    img[ 4*UW +: UW] = uw(S_RST,  3'd0, 6'd0,  17'h00010);
    img[ 6*UW +: UW] = uw(S_RST,  3'd0, 6'd0,  17'h00020);
    img[ 7*UW +: UW] = uw(S_CJT,  3'd0, 6'd10, 17'h08001);
    img[ 8*UW +: UW] = uw(S_CJF,  3'd1, 6'd11, 17'h00040);
    img[ 9*UW +: UW] = uw(S_RST,  3'd0, 6'd0,  17'h00000);
    img[10*UW +: UW] = uw(S_RST,  3'd0, 6'd0,  17'h02000);
    img[11*UW +: UW] = uw(S_CJT,  3'd5, 6'd0,  17'h00080);
    img[13*UW +: UW] = uw(S_RST,  3'd0, 6'd0,  17'h00004);
    img[20*UW +: UW] = uw(S_WAIT, 3'd0, 6'd0,  17'h00100);
    img[21*UW +: UW] = uw(S_RST,  3'd0, 6'd0,  17'h00200);
    img[23*UW +: UW] = uw(S_WAIT, 3'd0, 6'd0,  17'h00400);
    img[30*UW +: UW] = uw(S_NEXT, 3'd0, 6'd0,  17'h10001);
    img[31*UW +: UW] = uw(S_NEXT, 3'd0, 6'd0,  17'h04800);
    img[32*UW +: UW] = uw(S_RST,  3'd0, 6'd0,  17'h00800);
    img[33*UW +: UW] = uw(S_JUMP, 3'd0, 6'd40, 17'h01000);
    return img;
  endfunction

  function automatic logic [32*DW-1:0] build_disp_a();
    logic [32*DW-1:0] img;
    img = '0;
    img[1*DW +: DW] = {1'b1, 6'd23};
    img[2*DW +: DW] = {1'b1, 6'd2};
    img[3*DW +: DW] = {1'b1, 6'd20};
    img[4*DW +: DW] = {1'b1, 6'd30};
    img[5*DW +: DW] = {1'b1, 6'd33};
    img[6*DW +: DW] = {1'b1, 6'd7};
    img[9*DW +: DW] = {1'b1, 6'd13};
    return img;
  endfunction

  function automatic logic [64*UW-1:0] build_ucode_b();
    logic [64*UW-1:0] img;
    img = '0;
    img[ 0*UW +: UW] = uw(S_JUMP, 3'd0, 6'd62, 17'h00008);
    img[62*UW +: UW] = uw(S_NEXT, 3'd0, 6'd0,  17'h00010);
    img[63*UW +: UW] = uw(S_NEXT, 3'd0, 6'd0,  17'h1FFFF);
    return img;
  endfunction

  localparam logic [36*UW-1:0] UCODE_A = build_ucode_a();
  localparam logic [32*DW-1:0] DISP_A  = build_disp_a();
  localparam logic [64*UW-1:0] UCODE_B = build_ucode_b();

  logic        clk = 1'b0;
  logic        reset, in_stall, in_ready;
  logic [15:0] in_ir;
  logic [3:0]  in_alu_flags, in_stack_flags;

  logic [16:0] ctrl_a, ctrl_b;
  logic [7:0]  cu_out_a, cu_out_b;
  logic        cu_en_a, cu_en_b, illegal_a, illegal_b;
  logic [3:0]  flags_a, flags_b;
  logic [5:0]  pc_a, pc_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  microseq_control_unit #(
    .UDEPTH(36), .UCODE_IMAGE(UCODE_A), .DISPATCH_IMAGE(DISP_A)
  ) dut (
    .clk(clk), .reset(reset), .in_ir(in_ir), .in_alu_flags(in_alu_flags),
    .in_stack_flags(in_stack_flags), .in_stall(in_stall), .in_ready(in_ready),
    .out_ctrl(ctrl_a), .out_cu_out(cu_out_a), .out_cu_out_en(cu_en_a),
    .out_flags(flags_a), .out_micro_pc(pc_a), .out_illegal(illegal_a)
  );

  microseq_control_unit #(
    .UDEPTH(64), .UCODE_IMAGE(UCODE_B), .DISPATCH_IMAGE('0)
  ) dut_wrap (
    .clk(clk), .reset(reset), .in_ir(in_ir), .in_alu_flags(in_alu_flags),
    .in_stack_flags(in_stack_flags), .in_stall(in_stall), .in_ready(in_ready),
    .out_ctrl(ctrl_b), .out_cu_out(cu_out_b), .out_cu_out_en(cu_en_b),
    .out_flags(flags_b), .out_micro_pc(pc_b), .out_illegal(illegal_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_ir = 16'h0800; in_alu_flags = 4'h0; in_stack_flags = 4'h0;
    in_stall = 1'b0; in_ready = 1'b0;
    tick(); tick();
    reset = 1'b0; #1;
    check("init_pc",      32'(pc_a),      32'd0);
    check("init_ctrl",    32'(ctrl_a),    32'h00002);
    check("init_flags",   32'(flags_a),   32'd0);

    // Reset held two cycles while parked in the WAIT word at 23, with ready pending
    tick();
    check("to_wait23_pc",   32'(pc_a),   32'd23);
    check("wait23_ctrl",    32'(ctrl_a), 32'h00400);
    tick();
    check("wait23_hold",    32'(pc_a),   32'd23);
    reset = 1'b1; in_ready = 1'b1;
    tick();
    check("rst_mid_wait_pc", 32'(pc_a), 32'd0);
    tick();
    reset = 1'b0; in_ready = 1'b0; in_ir = 16'h4800; #1;
    check("rst_pc",       32'(pc_a),      32'd0);
    check("rst_flags",    32'(flags_a),   32'd0);
    check("rst_illegal",  32'(illegal_a), 32'd0);
    check("rst_ctrl_w0",  32'(ctrl_a),    32'h00002);
    check("w0_cu_en",     32'(cu_en_a),   32'd0);

    // Dispatch: opcode 9 -> 13; opcode 31 invalid -> trap
    tick();
    check("disp9_pc",     32'(pc_a),      32'd13);
    check("disp9_ctrl",   32'(ctrl_a),    32'h00004);
    tick();
    check("w13_reset_pc", 32'(pc_a),      32'd0);
    in_ir = 16'hF800; #1;
    check("illegal_hi",   32'(illegal_a), 32'd1);
    tick();
    check("trap_pc",      32'(pc_a),      32'd0);
    in_ir = 16'h1000; #1;
    check("illegal_lo",   32'(illegal_a), 32'd0);

    // Conditional jump taken on loaded flag
    in_alu_flags = 4'b0001;
    tick();
    check("alu_word_ctrl", 32'(ctrl_a),  32'h00005);
    tick();
    check("cjt_flags_ld",  32'(flags_a), 32'h1);
    tick();
    check("cjt_taken_pc",  32'(pc_a),    32'd6);
    tick();
    // Conditional jump not taken with flags cleared
    in_alu_flags = 4'b0000;
    tick(); tick();
    check("cjt_flags_clr", 32'(flags_a), 32'h0);
    tick();
    check("cjt_fall_pc",   32'(pc_a),    32'd4);
    tick();
    check("back_to_0",     32'(pc_a),    32'd0);
    // Load and branch in the same word: branch sees the old flags
    in_ir = 16'h3000; in_alu_flags = 4'b0001;
    tick();
    check("same_word_pc",    32'(pc_a),    32'd7);
    tick();
    check("same_word_old",   32'(pc_a),    32'd8);
    check("same_word_flags", 32'(flags_a), 32'h1);
    tick();
    check("cjf_taken_pc",    32'(pc_a),    32'd11);
    tick();
    check("cjt_always_pc",   32'(pc_a),    32'd0);

    // Flag priority, with a two-cycle stall on the load word
    in_ir = 16'h203C; in_alu_flags = 4'hA; in_stack_flags = 4'h5;
    tick();
    check("prio_word_ctrl", 32'(ctrl_a), 32'h10001);
    in_stall = 1'b1; #1;
    check("stall_ctrl",     32'(ctrl_a),  32'h0);
    check("stall_cu_en",    32'(cu_en_a), 32'd0);
    tick();
    check("stall1_pc",      32'(pc_a),    32'd30);
    check("stall1_flags",   32'(flags_a), 32'h1);
    tick();
    check("stall2_pc",      32'(pc_a),    32'd30);
    check("stall2_flags",   32'(flags_a), 32'h1);
    in_stall = 1'b0; #1;
    check("resume_ctrl",    32'(ctrl_a),  32'h10001);
    tick();
    check("prio_flags",     32'(flags_a),  32'h5);
    check("flagout_value",  32'(cu_out_a), 32'h05);
    check("flagout_en",     32'(cu_en_a),  32'd1);
    tick();
    check("imm_value",      32'(cu_out_a), 32'h3C);
    check("imm_en",         32'(cu_en_a),  32'd1);
    tick();

    // WAIT handshake at 20: three cycles not ready, released in the fourth
    in_ir = 16'h1800; in_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wait_pc",   32'(pc_a),   32'd20);
      check("wait_ctrl", 32'(ctrl_a), 32'h00100);
      tick();
    end
    in_ready = 1'b1; #1;
    check("wait4_pc",    32'(pc_a),   32'd20);
    check("wait4_ctrl",  32'(ctrl_a), 32'h00100);
    tick();
    check("wait_done_pc",   32'(pc_a),   32'd21);
    check("wait_done_ctrl", 32'(ctrl_a), 32'h00200);
    in_ready = 1'b0;
    tick();

    // Jump beyond the populated words
    in_ir = 16'h2800;
    tick();
    check("jmp_word_ctrl", 32'(ctrl_a),  32'h01000);
    tick();
    check("oor_pc",        32'(pc_a),    32'd40);
    check("oor_ctrl",      32'(ctrl_a),  32'h0);
    check("oor_cu_en",     32'(cu_en_a), 32'd0);
    tick();
    check("oor_restart",   32'(pc_a),    32'd0);

    // Wrap-around on the fully populated instance
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("wrap_rst_pc",   32'(pc_b),      32'd0);
    check("wrap_w0_ctrl",  32'(ctrl_b),    32'h00008);
    tick();
    check("wrap_62_pc",    32'(pc_b),      32'd62);
    check("wrap_62_ill",   32'(illegal_b), 32'd0);
    tick();
    check("wrap_63_pc",    32'(pc_b),      32'd63);
    check("wrap_63_ctrl",  32'(ctrl_b),    32'h1FFFF);
    check("wrap_63_cu_en", 32'(cu_en_b),   32'd1);
    tick();
    check("wrap_to_0",     32'(pc_b),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
